// File: rtl/lag_meter.sv
// lag_meter: measures display input lag, in whole microseconds, from the
// flash-start trigger to the debounced rise of the photosensor. Results and
// timeouts are reported as one-cycle pulses in the pixel-clock domain.
module lag_meter #(
    parameter int CLK_PER_US      = 74,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_US      = 500000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        starttrigger,
    input  logic        sensor_in,
    output logic [19:0] lag_us,
    output logic        lag_valid,
    output logic        lag_timeout,
    output logic        busy,
    output logic [7:0]  sample_count
);

    localparam int PW = $clog2(CLK_PER_US);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_PER_US - 1);
    localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0]   TIMEOUT_LIM = 20'(TIMEOUT_US);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t        state, state_next;
    logic          sync1, sync2;
    logic          sensor_db, sensor_db_q;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] presc;
    logic [19:0]   us;
    logic          rise;
    logic          restart;
    logic          do_result;
    logic          do_timeout;

    assign rise = sensor_db & ~sensor_db_q;

    // Synchronise the sensor and accept a new level only after it has held
    // for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sensor_db   <= 1'b0;
            sensor_db_q <= 1'b0;
            db_cnt      <= '0;
        end else begin
            sync1       <= sensor_in;
            sync2       <= sync1;
            sensor_db_q <= sensor_db;
            if (sync2 != sensor_db) begin
                if (db_cnt == DB_MAX) begin
                    sensor_db <= sync2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and event decode; a rise beats a retrigger, which beats timeout.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        do_result  = 1'b0;
        do_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (starttrigger) begin
                    state_next = S_MEASURE;
                    restart    = 1'b1;
                end
            end
            S_MEASURE: begin
                if (rise) begin
                    do_result  = 1'b1;
                    state_next = S_HOLDOFF;
                end else if (starttrigger) begin
                    do_timeout = 1'b1;
                    restart    = 1'b1;
                end else if (us == TIMEOUT_LIM) begin
                    do_timeout = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (!sensor_db) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Microsecond timebase: prescaler wraps every CLK_PER_US cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            us    <= '0;
        end else if (restart) begin
            presc <= '0;
            us    <= '0;
        end else if (state == S_MEASURE) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                us    <= us + 20'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Registered outputs: result capture, pulses, busy flag, saturating count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lag_us       <= '0;
            lag_valid    <= 1'b0;
            lag_timeout  <= 1'b0;
            busy         <= 1'b0;
            sample_count <= '0;
        end else begin
            lag_valid   <= do_result;
            lag_timeout <= do_timeout;
            busy        <= (state_next == S_MEASURE);
            if (do_result) begin
                lag_us <= us;
                if (sample_count != '1) begin
                    sample_count <= sample_count + 8'd1;
                end
            end
        end
    end

endmodule
